// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b one bit per clock, LSB first, and then
// publishes the difference, final borrow and Z/N/V flags with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             z,
    output logic             n,
    output logic             v
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
    logic             a_msb_q, b_msb_q, br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, bout_q, z_q, n_q, v_q;
    logic [WIDTH-1:0] d_q;

    logic load, step, finish;
    logic diff, br_d;

    assign diff = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    assign br_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                load    = 1'b1;
                state_d = RUN;
            end
            // The cycle that sees all WIDTH bits done only publishes the result.
            RUN: if (cnt_q == LAST) begin
                finish  = 1'b1;
                state_d = DONE;
            end else begin
                step = 1'b1;
            end
            DONE: if (start) begin
                load    = 1'b1;
                state_d = RUN;
            end else begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_sh_q  <= a;
                b_sh_q  <= b;
                res_q   <= '0;
                a_msb_q <= a[WIDTH-1];
                b_msb_q <= b[WIDTH-1];
                br_q    <= 1'b0;
                cnt_q   <= '0;
            end else if (step) begin
                a_sh_q <= a_sh_q >> 1;
                b_sh_q <= b_sh_q >> 1;
                res_q  <= {diff, res_q[WIDTH-1:1]};
                br_q   <= br_d;
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

    // Result registers change only when entering DONE, so they stay stable through a following RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            busy_q <= (state_q == RUN) && (state_d == RUN);
            done_q <= finish;
            if (finish) begin
                d_q    <= res_q;
                bout_q <= br_q;
                z_q    <= (res_q == '0);
                n_q    <= res_q[WIDTH-1];
                v_q    <= (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign z    = z_q;
    assign n    = n_q;
    assign v    = v_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor, using an arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, bout, z, n, v;
    logic [W-1:0] d;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_d = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .d(d), .bout(bout), .z(z), .n(n), .v(v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference from plain arithmetic: wrapped difference, unsigned compare, signed range check.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] ed, output logic eb, output logic ez,
                         output logic en, output logic ev);
        longint r, lim;
        ed  = x - y;
        eb  = (x < y);
        ez  = (ed == 0);
        en  = ed[W-1];
        lim = longint'(1) << (W - 1);
        r   = longint'($signed(x)) - longint'($signed(y));
        ev  = (r >= lim) || (r < -lim);
    endtask

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; optionally pulses start mid-RUN.
    task automatic wait_done(input string tag, input int inj);
        int lat = 0;
        int busy_bad = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = (c == inj);
            if (c == inj) begin a = $urandom; b = $urandom; end
            if (done) begin lat = c; break; end
            if (!busy) busy_bad++;
            if (c == 20) chk({tag, " d_held"}, d, prev_d);
        end
        start = 1'b0;
        chk({tag, " latency"}, lat, W + 1);
        chk({tag, " busy_low"}, busy_bad, 0);
        chk({tag, " busy_at_done"}, busy, 0);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] ed;
        logic eb, ez, en, ev;
        model(x, y, ed, eb, ez, en, ev);
        chk({tag, " d"}, d, ed);
        chk({tag, " flags"}, {bout, z, n, v}, {eb, ez, en, ev});
        prev_d = ed;
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        start_op(x, y);
        wait_done(tag, 0);
        check_res(tag, x, y);
        @(posedge clk); #1;
        chk({tag, " single_pulse"}, done, 0);
        chk({tag, " hold"}, d, prev_d);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int seen;
        #1 reset = 1'b1;
        #1 chk("reset_outs", {busy, done, d, bout, z, n, v}, '0);
        @(negedge clk); reset = 1'b0;

        // Case 1-3: directed values with known results.
        full_op("c1", 32'd5, 32'd3);
        chk("c1 exact", {d, bout, z, n, v}, {32'd2, 4'b0000});
        full_op("c2", 32'd3, 32'd5);
        chk("c2 exact", {d, bout, z, n, v}, {32'hFFFFFFFE, 4'b1010});
        full_op("c3", 32'h80000000, 32'd1);
        chk("c3 exact", {d, bout, z, n, v}, {32'h7FFFFFFF, 4'b0001});

        // Case 4: equal operands, then back-to-back start in the DONE cycle.
        start_op(32'h12345678, 32'h12345678);
        wait_done("c4a", 0);
        check_res("c4a", 32'h12345678, 32'h12345678);
        chk("c4a z", z, 1);
        start = 1'b1; a = 32'd7; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("c4b", 0);
        check_res("c4b", 32'd7, 32'd2);
        chk("c4b d5", d, 32'd5);

        // Case 5: start pulsed mid-RUN must be ignored.
        ra = $urandom; rb = $urandom;
        start_op(ra, rb);
        wait_done("c5", 10);
        check_res("c5", ra, rb);

        // Case 6: reset 15 cycles into RUN aborts with no done pulse.
        start_op(32'd100, 32'd1);
        repeat (15) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("c6 reset_outs", {busy, done, d, bout, z, n, v}, '0);
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (done) seen++; end
        @(negedge clk); reset = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        chk("c6 no_done", seen, 0);
        prev_d = '0;
        ra = $urandom; rb = $urandom;
        full_op("c6 after", ra, rb);

        // Zero-operand corners and random sweep.
        full_op("a0", 32'd0, $urandom);
        full_op("b0", $urandom, 32'd0);
        full_op("ab0", 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) full_op("rand", $urandom, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
